// File: rtl/flag_pkg.sv
// Shared flag indices, default flag width and the stack-operation decode
// used by the condition-flag context register.
package flag_pkg;

  localparam int FLAG_Z        = 0;
  localparam int FLAG_V        = 1;
  localparam int FLAG_N        = 2;
  localparam int NUM_FLAGS_DEF = 3;

  typedef logic [NUM_FLAGS_DEF-1:0] flag_vec_t;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_OVF     = 3'd3,
    OP_UNF     = 3'd4,
    OP_ILLEGAL = 3'd5
  } stk_op_t;

  // Resolve the push/pop request against the current stack occupancy.
  function automatic stk_op_t decode_op(input logic push, input logic pop,
                                        input logic full, input logic empty);
    stk_op_t op;
    op = OP_NONE;
    if (push && pop)     op = OP_ILLEGAL;
    else if (push)       op = full  ? OP_OVF : OP_PUSH;
    else if (pop)        op = empty ? OP_UNF : OP_POP;
    return op;
  endfunction

  function automatic logic is_err_op(input stk_op_t op);
    return (op == OP_OVF) || (op == OP_UNF) || (op == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/flag_ctx_stack.sv
// LIFO of saved flag contexts. Callers only assert push when not full and
// pop when not empty; the count never leaves 0..DEPTH.
module flag_ctx_stack
  import flag_pkg::*;
#(
  parameter int W     = NUM_FLAGS_DEF,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_m1;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_cnt_m1 = r_cnt - 1'b1;
  assign w_wr_idx = r_cnt[AW-1:0];
  assign w_rd_idx = w_cnt_m1[AW-1:0];

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign cnt   = r_cnt;
  assign rdata = empty ? '0 : r_mem[w_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= '0;
    else if (push && !full)  r_cnt <= r_cnt + 1'b1;
    else if (pop && !empty)  r_cnt <= w_cnt_m1;
  end

  // Entries are unreachable while empty, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) r_mem[w_wr_idx] <= wdata;
  end

endmodule

// File: rtl/flag_ctx_reg.sv
// Condition-flag register with a save/restore context stack and a sticky
// error flag for overflow, underflow and simultaneous push+pop.
module flag_ctx_reg
  import flag_pkg::*;
#(
  parameter int NUM_FLAGS = NUM_FLAGS_DEF,
  parameter int DEPTH     = 4,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_en,
  input  logic [NUM_FLAGS-1:0] upd_mask,
  input  logic [NUM_FLAGS-1:0] upd_flags,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 stk_full,
  output logic                 stk_empty,
  output logic [CW-1:0]        stk_cnt,
  output logic                 err
);

  logic [NUM_FLAGS-1:0] r_flags;
  logic                 r_err;
  logic [NUM_FLAGS-1:0] w_rdata;
  logic [NUM_FLAGS-1:0] w_upd_val;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_err_ev;
  stk_op_t              w_op;

  assign w_op      = decode_op(push, pop, w_full, w_empty);
  assign w_push_ok = (w_op == OP_PUSH);
  assign w_pop_ok  = (w_op == OP_POP);
  assign w_err_ev  = is_err_op(w_op);
  assign w_upd_val = (r_flags & ~upd_mask) | (upd_flags & upd_mask);

  flag_ctx_stack #(
    .W     (NUM_FLAGS),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_ok),
    .pop   (w_pop_ok),
    .wdata (r_flags),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .cnt   (stk_cnt)
  );

  // A restore wins over the ALU; an illegal push+pop freezes the flags, while
  // a dropped push or pop still lets the ALU update through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_flags <= '0;
    else if (w_op == OP_ILLEGAL) r_flags <= r_flags;
    else if (w_pop_ok)           r_flags <= w_rdata;
    else if (upd_en)             r_flags <= w_upd_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_err_ev) r_err <= 1'b1;
    else if (clr_err)  r_err <= 1'b0;
  end

  assign flags     = r_flags;
  assign err       = r_err;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;

endmodule

// File: tb/tb_flag_ctx_reg.sv
// Directed bench for flag_ctx_reg: masked update, save/restore, overflow,
// underflow, error clearing, illegal ops, pop priority and async reset.
module tb_flag_ctx_reg;

  localparam int NF = 3;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_en = 1'b0;
  logic [NF-1:0] upd_mask = '0;
  logic [NF-1:0] upd_flags = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [NF-1:0] flags;
  logic          stk_full;
  logic          stk_empty;
  logic [CW-1:0] stk_cnt;
  logic          err;

  int checks = 0;
  int errors = 0;

  flag_ctx_reg #(.NUM_FLAGS(NF), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (upd_en),
    .upd_mask  (upd_mask),
    .upd_flags (upd_flags),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .flags     (flags),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_cnt   (stk_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NF-1:0] f, input int c,
                         input logic fu, input logic em, input logic e);
    chk({tag, ".flags"}, 32'(flags), 32'(f));
    chk({tag, ".cnt"},   32'(stk_cnt), 32'(c));
    chk({tag, ".full"},  32'(stk_full), 32'(fu));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(em));
    chk({tag, ".err"},   32'(err), 32'(e));
  endtask

  // Drive one cycle of inputs, let the edge take them, then idle the inputs.
  task automatic step(input logic pu, input logic po, input logic ue,
                      input logic [NF-1:0] m, input logic [NF-1:0] u, input logic ce);
    push = pu; pop = po; upd_en = ue; upd_mask = m; upd_flags = u; clr_err = ce;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; upd_en = 1'b0; upd_mask = '0; upd_flags = '0; clr_err = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_all("reset", 3'b000, 0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Masked update
    step(0, 0, 1, 3'b101, 3'b111, 0);
    chk_all("mask_upd", 3'b101, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 0, 3'b111, 3'b010, 0);
    chk("upd_en_low", 32'(flags), 32'(3'b101));

    // Save and restore with an update alongside the push
    step(0, 0, 1, 3'b111, 3'b110, 0);
    chk("set_110", 32'(flags), 32'(3'b110));
    step(1, 0, 1, 3'b111, 3'b001, 0);
    chk_all("push_upd", 3'b001, 1, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("pop_restore", 3'b110, 0, 1'b0, 1'b1, 1'b0);

    // Fill the stack, then overflow; saved values are 110,001,010,011
    step(1, 0, 1, 3'b111, 3'b001, 0);
    step(1, 0, 1, 3'b111, 3'b010, 0);
    step(1, 0, 1, 3'b111, 3'b011, 0);
    chk_all("push3", 3'b011, 3, 1'b0, 1'b0, 1'b0);
    step(1, 0, 1, 3'b111, 3'b100, 0);
    chk_all("push4_full", 3'b100, 4, 1'b1, 1'b0, 1'b0);
    step(1, 0, 1, 3'b111, 3'b111, 0);
    chk_all("overflow", 3'b111, 4, 1'b1, 1'b0, 1'b1);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("pop1", 3'b011, 3, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("pop2", 3'b010, 2, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("pop3", 3'b001, 1, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("pop4", 3'b110, 0, 1'b0, 1'b1, 1'b1);

    // Clear, underflow with update, clear, clear racing a new underflow
    step(0, 0, 1, 3'b111, 3'b000, 1);
    chk_all("clr_and_zero", 3'b000, 0, 1'b0, 1'b1, 1'b0);
    step(0, 1, 1, 3'b010, 3'b010, 0);
    chk_all("underflow_upd", 3'b010, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0, 3'b000, 3'b000, 0);
    chk("err_sticky", 32'(err), 32'(1'b1));
    step(0, 0, 0, 3'b000, 3'b000, 1);
    chk("clr_err", 32'(err), 32'(1'b0));
    step(0, 1, 0, 3'b000, 3'b000, 1);
    chk_all("clr_vs_unf", 3'b010, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0, 3'b000, 3'b000, 1);

    // Illegal push+pop, then pop beats a same-cycle update
    step(1, 0, 1, 3'b111, 3'b101, 0);
    chk_all("push_101", 3'b101, 1, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1, 3'b111, 3'b111, 0);
    chk_all("illegal", 3'b101, 1, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, 3'b000, 3'b000, 1);
    chk("clr_after_illegal", 32'(err), 32'(1'b0));
    step(0, 1, 1, 3'b111, 3'b111, 0);
    chk_all("pop_priority", 3'b010, 0, 1'b0, 1'b1, 1'b0);

    // Async reset between edges with three entries and flags=111
    step(1, 0, 1, 3'b111, 3'b111, 0);
    step(1, 0, 0, 3'b000, 3'b000, 0);
    step(1, 1, 0, 3'b000, 3'b000, 0);
    step(1, 0, 0, 3'b000, 3'b000, 0);
    chk_all("pre_reset", 3'b111, 3, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 3'b000, 0, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b0;
    step(0, 0, 1, 3'b111, 3'b011, 0);
    chk_all("post_reset_upd", 3'b011, 0, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0, 3'b000, 3'b000, 0);
    step(0, 1, 0, 3'b000, 3'b000, 0);
    chk_all("post_reset_pushpop", 3'b011, 0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
